// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: shares one Avalon-MM master port (m1) between NUM_REQ
// requesters. Grants rotate round-robin, and each grant is capped at
// MAX_BURST accepted transfers. Each issued read records its requester in a
// pending FIFO, which routes every readdatavalid beat back to its owner.
// Build option: define GPU_ARB_FIXED_PRIORITY_EN for fixed priority, where
// the lowest index wins and there is no rotation pointer.
//
// state | meaning
// IDLE  | m1 idle; choose the next requester (one-cycle arbitration)
// GRANT | requester `grant` drives m1 until the burst cap is hit or it goes quiet
module gpu_mem_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int MAX_PENDING = 4,
    parameter int MAX_BURST   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ*32-1:0]  req_address,
    input  logic [NUM_REQ-1:0]     req_read,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*8-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    output logic [7:0]             req_readdata,
    output logic [NUM_REQ-1:0]     req_readdatavalid,
    output logic [31:0]            m1_address,
    output logic [7:0]             m1_writedata,
    output logic                   m1_read,
    output logic                   m1_write,
    input  logic                   m1_waitrequest,
    input  logic [7:0]             m1_readdata,
    input  logic                   m1_readdatavalid,
    output logic                   busy,
    output logic                   rsp_error
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] grant, grant_nxt;
    logic [BW-1:0] burst_cnt, burst_cnt_nxt;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] winner;
    logic          any_req;
    int            best_dist, cand_dist;

    logic          g_read, g_write;
    logic [31:0]   g_address;
    logic [7:0]    g_writedata;
    logic          accept, push, pop, end_grant;
    logic          pending_full, pending_empty;

    logic [IW-1:0] fifo_mem [MAX_PENDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

`ifdef GPU_ARB_FIXED_PRIORITY_EN
    assign start_idx = '0;
`else
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] next_after_grant;

    assign next_after_grant = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign start_idx        = rr_ptr;

    // Rotation pointer: the requester after the one whose grant just ended gets first look.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (state == GRANT && end_grant)
            rr_ptr <= next_after_grant;
    end
`endif

    assign any_req = |(req_read | req_write);

    // Winner = active requester with the smallest rotational distance from start_idx.
    always_comb begin
        best_dist = NUM_REQ;
        cand_dist = 0;
        winner    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_dist = (i + NUM_REQ - int'(start_idx)) % NUM_REQ;
            if ((req_read[i] | req_write[i]) && cand_dist < best_dist) begin
                best_dist = cand_dist;
                winner    = IW'(i);
            end
        end
    end

    // Mux the granted requester's command onto local signals.
    always_comb begin
        g_read      = 1'b0;
        g_write     = 1'b0;
        g_address   = '0;
        g_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IW'(i)) begin
                g_read      = req_read[i];
                g_write     = req_write[i];
                g_address   = req_address[32*i +: 32];
                g_writedata = req_writedata[8*i +: 8];
            end
        end
    end

    // FSM next state, m1 drive and per-requester stalls.
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        burst_cnt_nxt   = burst_cnt;
        m1_read         = 1'b0;
        m1_write        = 1'b0;
        m1_address      = '0;
        m1_writedata    = '0;
        req_waitrequest = '1;
        accept          = 1'b0;
        end_grant       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt     = GRANT;
                    grant_nxt     = winner;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                // A read blocked only by a full pending FIFO keeps the grant.
                m1_read      = g_read & ~pending_full;
                m1_write     = g_write;
                m1_address   = g_address;
                m1_writedata = g_writedata;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant == IW'(i))
                        req_waitrequest[i] = m1_waitrequest | (g_read & pending_full);
                end
                accept = (m1_read | m1_write) & ~m1_waitrequest;
                if (accept)
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end_grant = (accept && burst_cnt == BW'(MAX_BURST - 1)) || (!g_read && !g_write);
                if (end_grant)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, grant and burst counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign push          = accept & m1_read;
    assign pending_empty = (count == '0);
    assign pending_full  = (count == (PW+1)'(MAX_PENDING));
    assign pop           = m1_readdatavalid & ~pending_empty;

    // Pending FIFO storage; an entry is valid only while counted, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= grant;
    end

    // Pending FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Route the returning beat to the requester at the FIFO head.
    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop && fifo_mem[rd_ptr] == IW'(i))
                req_readdatavalid[i] = 1'b1;
        end
    end

    assign req_readdata = m1_readdata;
    assign busy         = (state == GRANT) | ~pending_empty;

    // Sticky flag for a response beat that no outstanding read accounts for.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rsp_error <= 1'b0;
        else if (m1_readdatavalid && pending_empty)
            rsp_error <= 1'b1;
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Self-checking bench for gpu_mem_arbiter (NUM_REQ=3, MAX_PENDING=4, MAX_BURST=8).
module tb_gpu_mem_arbiter;
    localparam int N = 3;
`ifdef GPU_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRI = 1'b1;
`else
    localparam bit FIXED_PRI = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N*32-1:0] req_address;
    logic [N-1:0]    req_read, req_write;
    logic [N*8-1:0]  req_writedata;
    logic [N-1:0]    req_waitrequest, req_readdatavalid;
    logic [7:0]      req_readdata;
    logic [31:0]     m1_address;
    logic [7:0]      m1_writedata, m1_readdata;
    logic            m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
    logic            busy, rsp_error;

    always #5 clock = ~clock;

    gpu_mem_arbiter #(.NUM_REQ(N), .MAX_PENDING(4), .MAX_BURST(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
        .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .busy(busy), .rsp_error(rsp_error)
    );

    typedef struct {
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic         mw;
        logic         mv;
        logic [7:0]   md;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_addr;
        logic [N-1:0] e_wait;
        logic [N-1:0] e_rdv;
        logic         e_busy;
    } vec_t;

    vec_t       vecs[8];
    vec_t       exp_q[$];
    vec_t       e;
    int         exp_owner_q[$];
    logic [7:0] exp_data_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_read = '0; req_write = '0; req_address = '0; req_writedata = '0;
        m1_waitrequest = 1'b0; m1_readdata = '0; m1_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc_chk(input string tag, input logic erd, input logic [N-1:0] ewait,
                           input logic [N-1:0] erdv, input logic ebusy);
        @(negedge clock);
        chk({tag, " m1_read"}, 32'(m1_read), 32'(erd));
        chk({tag, " waitreq"}, 32'(req_waitrequest), 32'(ewait));
        chk({tag, " rdv"}, 32'(req_readdatavalid), 32'(erdv));
        chk({tag, " busy"}, 32'(busy), 32'(ebusy));
    endtask

    // Requesters in `mask` read back to back; the slave answers each accepted read one cycle later.
    task automatic run_stream(input logic [N-1:0] mask, input int nslots, input string tag);
        int         beat[N];
        int         ptr, owner, phase, idx, last_c, o;
        bit         found, active, exp_rd;
        logic       prev_acc;
        logic [7:0] prev_byte, ebyte;
        logic [N-1:0] exp_wait, oh;
        logic [31:0]  exp_addr;
        do_reset();
        ptr = 0; owner = 0; prev_acc = 1'b0; prev_byte = '0; exp_addr = '0;
        for (int i = 0; i < N; i++) beat[i] = 0;
        last_c = nslots * 9 + 1;
        for (int c = 0; c <= last_c; c++) begin
            active = (c < nslots * 9);
            phase  = c % 9;
            next_cycle();
            if (active && phase == 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (!found && mask[idx]) begin
                        owner = idx;
                        found = 1'b1;
                    end
                end
                if (!FIXED_PRI) ptr = (owner + 1) % N;
            end
            req_read = active ? mask : '0;
            for (int i = 0; i < N; i++) req_address[32*i +: 32] = 32'((i << 6) | beat[i]);
            m1_readdatavalid = prev_acc;
            m1_readdata      = prev_byte;
            exp_rd   = active && (phase != 0);
            exp_wait = '1;
            if (exp_rd) begin
                exp_wait[owner] = 1'b0;
                exp_addr = 32'((owner << 6) | beat[owner]);
                exp_owner_q.push_back(owner);
                exp_data_q.push_back(exp_addr[7:0]);
                beat[owner]++;
            end
            @(negedge clock);
            chk($sformatf("%s c%0d m1_read", tag, c), 32'(m1_read), 32'(exp_rd));
            if (exp_rd) chk($sformatf("%s c%0d m1_address", tag, c), m1_address, exp_addr);
            chk($sformatf("%s c%0d waitreq", tag, c), 32'(req_waitrequest), 32'(exp_wait));
            if (m1_readdatavalid) begin
                chk($sformatf("%s c%0d sb_nonempty", tag, c), 32'(exp_owner_q.size() > 0), 32'd1);
                if (exp_owner_q.size() > 0) begin
                    o = exp_owner_q.pop_front();
                    ebyte = exp_data_q.pop_front();
                    oh = '0;
                    oh[o] = 1'b1;
                    chk($sformatf("%s c%0d route", tag, c), 32'(req_readdatavalid), 32'(oh));
                    chk($sformatf("%s c%0d rdata", tag, c), 32'(req_readdata), 32'(ebyte));
                end
            end
            prev_acc  = m1_read & ~m1_waitrequest;
            prev_byte = m1_address[7:0];
        end
        chk({tag, " sb_drained"}, 32'(exp_owner_q.size()), 32'd0);
        exp_owner_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clear_inputs();

        // Single read: two slave wait cycles, data 0x5A three cycles after the accept.
        vecs[0] = '{3'b010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,    3'b111, 3'b000, 1'b0};
        vecs[1] = '{3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h1000, 3'b111, 3'b000, 1'b1};
        vecs[2] = '{3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h1000, 3'b111, 3'b000, 1'b1};
        vecs[3] = '{3'b010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h1000, 3'b101, 3'b000, 1'b1};
        vecs[4] = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h1000, 3'b101, 3'b000, 1'b1};
        vecs[5] = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,    3'b111, 3'b000, 1'b1};
        vecs[6] = '{3'b000, 3'b000, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 32'h0,    3'b111, 3'b010, 1'b1};
        vecs[7] = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,    3'b111, 3'b000, 1'b0};

        do_reset();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst waitreq", 32'(req_waitrequest), 32'h7);
        chk("rst m1_read", 32'(m1_read), 32'd0);
        chk("rst rsp_error", 32'(rsp_error), 32'd0);
        req_address[63:32] = 32'h0000_1000;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            req_read = vecs[i].rd; req_write = vecs[i].wr;
            m1_waitrequest = vecs[i].mw; m1_readdatavalid = vecs[i].mv; m1_readdata = vecs[i].md;
            exp_q.push_back(vecs[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            chk($sformatf("A%0d m1_read", i), 32'(m1_read), 32'(e.e_rd));
            chk($sformatf("A%0d m1_write", i), 32'(m1_write), 32'(e.e_wr));
            chk($sformatf("A%0d m1_address", i), m1_address, e.e_addr);
            chk($sformatf("A%0d waitreq", i), 32'(req_waitrequest), 32'(e.e_wait));
            chk($sformatf("A%0d rdv", i), 32'(req_readdatavalid), 32'(e.e_rdv));
            chk($sformatf("A%0d busy", i), 32'(busy), 32'(e.e_busy));
            if (e.e_rdv != '0) chk($sformatf("A%0d rdata", i), 32'(req_readdata), 32'(e.md));
        end

        // All three streaming; then only 0 and 2 (rotation or fixed priority depending on build).
        run_stream(3'b111, 4, "RR");
        run_stream(3'b101, 3, "P02");

        // Pending FIFO fills at four outstanding reads; a response frees a slot.
        do_reset();
        req_address[31:0] = 32'h40;
        next_cycle(); req_read = 3'b001;
        cyc_chk("C0", 1'b0, 3'b111, 3'b000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            cyc_chk($sformatf("C%0d", k), 1'b1, 3'b110, 3'b000, 1'b1);
        end
        next_cycle();
        cyc_chk("C5 full", 1'b0, 3'b111, 3'b000, 1'b1);
        next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'h11;
        cyc_chk("C6 free", 1'b0, 3'b111, 3'b001, 1'b1);
        chk("C6 rdata", 32'(req_readdata), 32'h11);
        next_cycle(); m1_readdatavalid = 1'b0;
        cyc_chk("C7 fifth", 1'b1, 3'b110, 3'b000, 1'b1);
        next_cycle(); req_read = '0;
        cyc_chk("C8", 1'b0, 3'b110, 3'b000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'(8'h20 + k);
            cyc_chk($sformatf("C drain%0d", k), 1'b0, 3'b111, 3'b001, 1'b1);
        end
        next_cycle(); m1_readdatavalid = 1'b0;
        cyc_chk("C13", 1'b0, 3'b111, 3'b000, 1'b0);

        // Requester 0 writes while requester 2 has two reads outstanding.
        do_reset();
        req_address[95:64] = 32'h300; req_address[31:0] = 32'h20; req_writedata[7:0] = 8'hA5;
        next_cycle(); req_read = 3'b100;
        cyc_chk("D0", 1'b0, 3'b111, 3'b000, 1'b0);
        next_cycle();
        cyc_chk("D1", 1'b1, 3'b011, 3'b000, 1'b1);
        next_cycle();
        cyc_chk("D2", 1'b1, 3'b011, 3'b000, 1'b1);
        next_cycle(); req_read = '0; req_write = 3'b001;
        cyc_chk("D3", 1'b0, 3'b011, 3'b000, 1'b1);
        chk("D3 m1_write", 32'(m1_write), 32'd0);
        next_cycle();
        cyc_chk("D4", 1'b0, 3'b111, 3'b000, 1'b1);
        next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'h77;
        cyc_chk("D5", 1'b0, 3'b110, 3'b100, 1'b1);
        chk("D5 m1_write", 32'(m1_write), 32'd1);
        chk("D5 m1_address", m1_address, 32'h20);
        chk("D5 m1_writedata", 32'(m1_writedata), 32'hA5);
        chk("D5 rdata", 32'(req_readdata), 32'h77);
        next_cycle(); req_write = '0; m1_readdatavalid = 1'b0;
        cyc_chk("D6", 1'b0, 3'b110, 3'b000, 1'b1);
        next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'h78;
        cyc_chk("D7", 1'b0, 3'b111, 3'b100, 1'b1);
        next_cycle(); m1_readdatavalid = 1'b0;
        cyc_chk("D8", 1'b0, 3'b111, 3'b000, 1'b0);

        // Stray response sets the sticky error.
        do_reset();
        next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'h99;
        cyc_chk("E0", 1'b0, 3'b111, 3'b000, 1'b0);
        chk("E0 rsp_error", 32'(rsp_error), 32'd0);
        next_cycle(); m1_readdatavalid = 1'b0;
        @(negedge clock); chk("E1 rsp_error", 32'(rsp_error), 32'd1);
        next_cycle();
        @(negedge clock); chk("E2 rsp_error sticky", 32'(rsp_error), 32'd1);

        // Reset in the middle of a burst with three reads outstanding.
        do_reset();
        chk("E rst clears error", 32'(rsp_error), 32'd0);
        req_address[63:32] = 32'h500; req_writedata[15:8] = 8'hEE;
        next_cycle(); req_read = 3'b010;
        cyc_chk("R0", 1'b0, 3'b111, 3'b000, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            cyc_chk($sformatf("R%0d", k), 1'b1, 3'b101, 3'b000, 1'b1);
        end
        next_cycle(); m1_waitrequest = 1'b1;
        cyc_chk("R4", 1'b1, 3'b111, 3'b000, 1'b1);
        #1;
        reset_n = 1'b0; m1_readdatavalid = 1'b1; m1_readdata = 8'h42;
        #1;
        chk("Rrst m1_read", 32'(m1_read), 32'd0);
        chk("Rrst m1_write", 32'(m1_write), 32'd0);
        chk("Rrst m1_address", m1_address, 32'd0);
        chk("Rrst m1_writedata", 32'(m1_writedata), 32'd0);
        chk("Rrst waitreq", 32'(req_waitrequest), 32'h7);
        chk("Rrst rdv", 32'(req_readdatavalid), 32'd0);
        chk("Rrst busy", 32'(busy), 32'd0);
        chk("Rrst rsp_error", 32'(rsp_error), 32'd0);
        clear_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle(); m1_readdatavalid = 1'b1; m1_readdata = 8'h42;
        cyc_chk("Rlate", 1'b0, 3'b111, 3'b000, 1'b0);
        next_cycle(); m1_readdatavalid = 1'b0;
        @(negedge clock); chk("Rlate rsp_error", 32'(rsp_error), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
